gaussian_window_gen: RTL and testbench

Streaming 7x7 window generator that feeds gaussian_core. It accepts a raster-order 8-bit pixel stream, buffers the six previous image lines, and emits a 392-bit 7x7 neighbourhood with a valid strobe. Each window is packed in exactly the layout gaussian_core consumes on input_pixels. It sits between the pixel source (frame reader / DMA) and the filter core. Only windows lying fully inside the image are emitted; borders are dropped.

---
 rtl/gaussian_window_gen.sv | 134 +++++++++++++
 tb/tb_gaussian_window_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window_gen.sv
// gaussian_window_gen: streaming 7x7 window generator for gaussian_core.
// Buffers six previous lines of a raster 8-bit pixel stream and emits each
// fully-interior 7x7 neighbourhood, packed for gaussian_core input_pixels.
// Optional: define GAUSS_WIN_CNT_EN to add the 32-bit win_count output.
module gaussian_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [391:0]     win_out,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             frame_done
`ifdef GAUSS_WIN_CNT_EN
    ,
    output logic [31:0]      win_count
`endif
);

    localparam int WIN = 7;
    localparam int NLB = WIN - 1;
    localparam int AW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] EDGE     = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(WIN / 2);

    logic [CNT_W-1:0] row, col;
    logic [CNT_W-1:0] cur_row, cur_col;
    logic             start;
    logic             win_done;
    logic [AW-1:0]    addr;

    // Line buffers: lb[k] holds line row-(k+1); never cleared, stale data is gated out
    logic [7:0] lb  [NLB][IMG_WIDTH];
    // 7x7 shift window, [row][col], col 0 is the oldest column
    logic [7:0] win [WIN][WIN];
    logic [7:0] nxt [WIN][WIN];
    logic [391:0] nxt_packed;

    // Coordinate of the pixel being accepted; sof forces it to (0,0)
    always_comb begin
        start   = pix_valid & sof;
        cur_row = start ? '0 : row;
        cur_col = start ? '0 : col;
        addr    = cur_col[AW-1:0];
        // Window is complete once both 7 rows and 7 columns of this line exist
        win_done = pix_valid && (cur_row >= EDGE) && (cur_col >= EDGE);
    end

    // Next window: shift left by one column, append the new column on the right
    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                nxt[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < NLB; r++) begin
            nxt[r][WIN-1] = lb[NLB-1-r][addr];
        end
        nxt[WIN-1][WIN-1] = pix_in;
    end

    // Pack with top-left in the MSB byte and bottom-right in the LSB byte
    always_comb begin
        nxt_packed = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                nxt_packed[8*(WIN*WIN-1-(WIN*r+c)) +: 8] = nxt[r][c];
            end
        end
    end

    // Line-buffer cascade and window shift; storage only, no reset needed
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb[0][addr] <= pix_in;
            for (int k = 1; k < NLB; k++) begin
                lb[k][addr] <= lb[k-1][addr];
            end
            win <= nxt;
        end
    end

    // Raster counters and registered window/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            col        <= '0;
            win_out    <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= win_done;
            frame_done <= pix_valid && (cur_row == LAST_ROW) && (cur_col == LAST_COL);
            if (pix_valid) begin
                if (cur_col == LAST_COL) begin
                    col <= '0;
                    row <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
            if (win_done) begin
                win_out <= nxt_packed;
                win_row <= cur_row - HALF;
                win_col <= cur_col - HALF;
            end
        end
    end

`ifdef GAUSS_WIN_CNT_EN
    // Window throughput counter; a new frame start clears it ahead of counting
    always_ff @(posedge clk) begin
        if (rst) begin
            win_count <= '0;
        end else if (start) begin
            win_count <= '0;
        end else if (win_valid) begin
            win_count <= win_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gaussian_window_gen.sv
// Self-checking bench for gaussian_window_gen on an 8x8 image.
module tb_gaussian_window_gen;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [391:0]  win_out;
    logic          win_valid;
    logic [CW-1:0] win_row, win_col;
    logic          frame_done;
`ifdef GAUSS_WIN_CNT_EN
    logic [31:0]   win_count;
`endif

    gaussian_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .sof(sof),
        .win_out(win_out),
        .win_valid(win_valid),
        .win_row(win_row),
        .win_col(win_col),
        .frame_done(frame_done)
`ifdef GAUSS_WIN_CNT_EN
        ,
        .win_count(win_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           row;
        int           col;
        logic [391:0] data;
        int           cyc;
    } win_t;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] tl;
        logic [7:0] ctr;
        logic [7:0] br;
    } vec_t;

    win_t got_q[$];
    win_t exp_q[$];
    int   fd_q[$];
    int   exp_fd_q[$];
    logic [391:0] s1_data[$];

    int tests = 0;
    int fails = 0;

    logic [7:0] img [H][W];
    int m_row = 0;
    int m_col = 0;

    // Capture every output window and frame_done strobe away from the clock edge
    always @(negedge clk) begin
        if (win_valid) got_q.push_back('{int'(win_row), int'(win_col), win_out, cyc});
        if (frame_done) fd_q.push_back(cyc);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [391:0] act, input logic [391:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the bench's own raster model
    task automatic drive(input logic [7:0] v, input logic s, input logic vld);
        logic [391:0] d;
        @(negedge clk);
        pix_in = v;
        sof = s;
        pix_valid = vld;
        if (vld) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = v;
            if (m_row >= 6 && m_col >= 6) begin
                d = '0;
                for (int r = 0; r < 7; r++)
                    for (int c = 0; c < 7; c++)
                        d[8*(48-(7*r+c)) +: 8] = img[m_row-6+r][m_col-6+c];
                exp_q.push_back('{m_row - 3, m_col - 3, d, cyc + 1});
            end
            if (m_row == H-1 && m_col == W-1) exp_fd_q.push_back(cyc + 1);
            if (m_col == W-1) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    // Idle cycle: junk data and stray sof, both must be ignored
    task automatic idle();
        drive(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_frame(input int kind, input int npix, input bit use_sof, input bit gaps);
        int r, c;
        for (int k = 0; k < npix; k++) begin
            r = k / W;
            c = k % W;
            drive((kind == 0) ? 8'(8*r + c) : 8'(255 - (8*r + c)), use_sof && (k == 0), 1'b1);
            if (gaps) begin
                if (k % 2 == 0) idle();
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle();
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        sof = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
        chk("rst win_valid", win_valid, 0);
        chk_w("rst win_out", win_out, '0);
        chk("rst win_row", win_row, 0);
        chk("rst win_col", win_col, 0);
        chk("rst frame_done", frame_done, 0);
`ifdef GAUSS_WIN_CNT_EN
        chk("rst win_count", win_count, 0);
`endif
    endtask

    task automatic compare_run(input string tag, input int exp_n, input int exp_fd);
        repeat (4) idle();
        chk({tag, " windows"}, got_q.size(), exp_n);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk_w({tag, " data"}, got_q[i].data, exp_q[i].data);
            chk({tag, " row"}, got_q[i].row, exp_q[i].row);
            chk({tag, " col"}, got_q[i].col, exp_q[i].col);
            chk({tag, " latency"}, got_q[i].cyc, exp_q[i].cyc);
        end
        chk({tag, " frame_done count"}, fd_q.size(), exp_fd);
        for (int i = 0; i < fd_q.size() && i < exp_fd_q.size(); i++)
            chk({tag, " frame_done cycle"}, fd_q[i], exp_fd_q[i]);
        got_q.delete();
        exp_q.delete();
        fd_q.delete();
        exp_fd_q.delete();
    endtask

    vec_t tbl[4];

    initial begin
        // Hand-computed windows of the 8x8 ramp pixel = 8r + c
        tbl[0] = '{3, 3, 8'h00, 8'h1B, 8'h36};
        tbl[1] = '{3, 4, 8'h01, 8'h1C, 8'h37};
        tbl[2] = '{4, 3, 8'h08, 8'h23, 8'h3E};
        tbl[3] = '{4, 4, 8'h09, 8'h24, 8'h3F};

        do_reset();

        // Continuous ramp frame
        send_frame(0, W*H, 1'b1, 1'b0);
        repeat (4) idle();
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                chk("ramp tbl row", got_q[i].row, tbl[i].row);
                chk("ramp tbl col", got_q[i].col, tbl[i].col);
                chk("ramp tbl top-left", got_q[i].data[391:384], tbl[i].tl);
                chk("ramp tbl centre", got_q[i].data[199:192], tbl[i].ctr);
                chk("ramp tbl bottom-right", got_q[i].data[7:0], tbl[i].br);
                s1_data.push_back(got_q[i].data);
            end else begin
                chk("ramp tbl window present", 0, 1);
            end
        end
        compare_run("ramp", 4, 1);
`ifdef GAUSS_WIN_CNT_EN
        chk("ramp win_count", win_count, 4);
`endif

        // Same ramp with gapped pix_valid and stray sof on idle cycles
        send_frame(0, W*H, 1'b1, 1'b1);
        begin
            repeat (4) idle();
            for (int i = 0; i < got_q.size() && i < s1_data.size(); i++)
                chk_w("gaps vs ramp", got_q[i].data, s1_data[i]);
        end
        compare_run("gaps", 4, 1);

        // Back-to-back frames, second inverted and without sof
        send_frame(0, W*H, 1'b1, 1'b0);
        repeat (3) idle();
`ifdef GAUSS_WIN_CNT_EN
        chk("b2b win_count frame1", win_count, 4);
`endif
        send_frame(1, W*H, 1'b0, 1'b0);
        repeat (4) idle();
        if (got_q.size() > 4) begin
            chk("b2b f2 top-left", got_q[4].data[391:384], 8'hFF);
            chk("b2b f2 bottom-right", got_q[4].data[7:0], 8'hC9);
        end else begin
            chk("b2b f2 window present", 0, 1);
        end
        compare_run("b2b", 8, 2);
`ifdef GAUSS_WIN_CNT_EN
        chk("b2b win_count frame2", win_count, 8);
`endif

        // Frame aborted by sof at pixel 30
        send_frame(0, 30, 1'b1, 1'b0);
`ifdef GAUSS_WIN_CNT_EN
        chk("sof clears win_count", win_count, 0);
`endif
        send_frame(0, W*H, 1'b1, 1'b0);
        repeat (4) idle();
        if (got_q.size() > 0) begin
            chk("abort first row", got_q[0].row, 3);
            chk("abort first col", got_q[0].col, 3);
        end else begin
            chk("abort window present", 0, 1);
        end
        compare_run("abort", 4, 1);

        // Reset mid-frame after pixel 50, then a clean ramp frame
        send_frame(0, 50, 1'b1, 1'b0);
        do_reset();
        send_frame(0, W*H, 1'b1, 1'b0);
        repeat (4) idle();
        for (int i = 0; i < got_q.size() && i < s1_data.size(); i++)
            chk_w("post-rst vs ramp", got_q[i].data, s1_data[i]);
        compare_run("post-rst", 4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
